fetch_ctrl: RTL and testbench

Requester side of the instruction-memory fetch port. Drives `pc` into the dual-word instruction memory, tracks the one-cycle read latency, and captures the returned `inst1`/`inst2` pair into a small instruction queue. Presents up to two instructions per cycle, with their PCs, to decode over a valid/ready handshake. Handles redirects (branch/flush) from the back end.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_ctrl_chk.sv | 24 ++
 rtl/inst_queue.sv | 74 +++++++
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int PC_W   = 8;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] HALT_INST = 32'h0000_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [INST_W-1:0] word);
        return (word == HALT_INST);
    endfunction

endpackage

// File: rtl/fetch_ctrl_chk.sv
// Safety properties of the fetch queue: credit never overflows it and
// lane 1 is never valid without lane 0.
module fetch_ctrl_chk #(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] count,
    input  logic [1:0]       push_n,
    input  logic [1:0]       pop_n,
    input  logic             dec_valid0,
    input  logic             dec_valid1
);

    localparam int SUM_W = CNT_W + 2;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (SUM_W'(count) + SUM_W'(push_n)) <= (SUM_W'(DEPTH) + SUM_W'(pop_n)));

    a_lane_order: assert property (@(posedge clk) disable iff (!reset_n)
        dec_valid1 |-> dec_valid0);

endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue: up to two pushes and two pops per cycle,
// with the two oldest entries presented combinationally from storage.
module inst_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic [1:0]         push_n,
    input  fetch_entry_t       push0,
    input  fetch_entry_t       push1,
    input  logic               pop,
    output logic [1:0]         pop_n,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head0,
    output fetch_entry_t       head1
);

    fetch_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic [1:0]         pop_n_s;

    // Decode takes every valid lane, at most two, when it is ready.
    always_comb begin
        if (!pop) begin
            pop_n_s = 2'd0;
        end else if (count_r >= CNT_W'(2'd2)) begin
            pop_n_s = 2'd2;
        end else if (count_r == CNT_W'(1'b1)) begin
            pop_n_s = 2'd1;
        end else begin
            pop_n_s = 2'd0;
        end
    end

    // Entry storage; contents are don't-care until counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) begin
            mem_r[tail_r] <= push0;
        end
        if (push_n == 2'd2) begin
            mem_r[tail_r + PTR_W'(1'b1)] <= push1;
        end
    end

    // Pointer and occupancy bookkeeping; a flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_r + PTR_W'(pop_n_s);
            tail_r  <= tail_r + PTR_W'(push_n);
            count_r <= count_r + CNT_W'(push_n) - CNT_W'(pop_n_s);
        end
    end

    assign pop_n = pop_n_s;
    assign count = count_r;
    assign head0 = mem_r[head_r];
    assign head1 = mem_r[head_r + PTR_W'(1'b1)];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch requester: issues dual-word reads, queues returned pairs,
// feeds decode two lanes wide. Optional halt-word stop: FETCH_CTRL_HALT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] inst1,
    input  logic [INST_W-1:0] inst2,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              dec_ready,
    output logic              dec_valid0,
    output logic              dec_valid1,
    output logic [INST_W-1:0] dec_inst0,
    output logic [INST_W-1:0] dec_inst1,
    output logic [PC_W-1:0]   dec_pc0,
    output logic [PC_W-1:0]   dec_pc1,
    output logic              halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  pc_r;
    logic             pend_r;
    logic [PC_W-1:0]  pend_pc_r;
    logic             halted_s;
    logic             halt_hit_s;
    logic             capture_s;
    logic             issue_s;
    logic [1:0]       push_n_s;
    logic [1:0]       pop_n_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W:0]   credit_s;
    fetch_entry_t     push0_s;
    fetch_entry_t     push1_s;
    fetch_entry_t     head0_s;
    fetch_entry_t     head1_s;

    assign capture_s = pend_r && !redirect_valid;
    assign push0_s   = '{inst: inst1, pc: pend_pc_r};
    assign push1_s   = '{inst: inst2, pc: pend_pc_r + PC_W'(3'd4)};

    // Decide how many of the returning words enter the queue.
    always_comb begin
        push_n_s   = 2'd0;
        halt_hit_s = 1'b0;
        if (capture_s) begin
`ifdef FETCH_CTRL_HALT_EN
            if (is_halt(inst1)) begin
                push_n_s   = 2'd0;
                halt_hit_s = 1'b1;
            end else if (is_halt(inst2)) begin
                push_n_s   = 2'd1;
                halt_hit_s = 1'b1;
            end else begin
                push_n_s   = 2'd2;
            end
`else
            push_n_s = 2'd2;
`endif
        end else begin
            push_n_s = 2'd0;
        end
    end

    // In-flight words already hold two slots, so they are charged as credit.
    assign credit_s = {1'b0, count_s} + (CNT_W + 1)'({pend_r, 1'b0});
    assign issue_s  = !redirect_valid && !halted_s && !halt_hit_s &&
                      (credit_s <= (CNT_W + 1)'(DEPTH - 2));

    // Fetch address and the one-deep outstanding-read tracker.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_r      <= RESET_PC;
            pend_r    <= 1'b0;
            pend_pc_r <= '0;
        end else if (redirect_valid) begin
            pc_r      <= {redirect_pc[PC_W-1:2], 2'b00};
            pend_r    <= 1'b0;
        end else if (issue_s) begin
            pc_r      <= pc_r + PC_W'(4'd8);
            pend_r    <= 1'b1;
            pend_pc_r <= pc_r;
        end else begin
            pend_r    <= 1'b0;
        end
    end

`ifdef FETCH_CTRL_HALT_EN
    logic halted_r;

    // Sticky halt, released only by a redirect or reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            halted_r <= 1'b0;
        end else if (redirect_valid) begin
            halted_r <= 1'b0;
        end else if (halt_hit_s) begin
            halted_r <= 1'b1;
        end
    end

    assign halted_s = halted_r;
`else
    assign halted_s = 1'b0;
`endif

    inst_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect_valid),
        .push_n  (push_n_s),
        .push0   (push0_s),
        .push1   (push1_s),
        .pop     (dec_ready),
        .pop_n   (pop_n_s),
        .count   (count_s),
        .head0   (head0_s),
        .head1   (head1_s)
    );

    fetch_ctrl_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk        (clk),
        .reset_n    (reset_n),
        .count      (count_s),
        .push_n     (push_n_s),
        .pop_n      (pop_n_s),
        .dec_valid0 (dec_valid0),
        .dec_valid1 (dec_valid1)
    );

    assign pc         = pc_r;
    assign halted     = halted_s;
    assign dec_valid0 = (count_s != '0);
    assign dec_valid1 = (count_s >= CNT_W'(2'd2));
    assign dec_inst0  = head0_s.inst;
    assign dec_inst1  = head1_s.inst;
    assign dec_pc0    = head0_s.pc;
    assign dec_pc1    = head1_s.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: queue-level behavioural model compared
// every cycle, plus an in-order accepted-PC check and literal spot checks.
module tb_fetch_ctrl;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] inst;
        logic [7:0]  pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  pc;
    logic [31:0] inst1;
    logic [31:0] inst2;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        dec_ready;
    logic        dec_valid0;
    logic        dec_valid1;
    logic [31:0] dec_inst0;
    logic [31:0] dec_inst1;
    logic [7:0]  dec_pc0;
    logic [7:0]  dec_pc1;
    logic        halted;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [64];

    ent_t       m_q[$];
    ent_t       n_q[$];
    logic [7:0] m_pc, n_pc, m_pend_pc, n_pend_pc;
    bit         m_pend, n_pend, m_halted, n_halted;
    bit         chk_en = 1'b0;
    logic [7:0] exp_acc = 8'h00;

    fetch_ctrl #(
        .PC_W     (8),
        .INST_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc             (pc),
        .inst1          (inst1),
        .inst2          (inst2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .dec_valid0     (dec_valid0),
        .dec_valid1     (dec_valid1),
        .dec_inst0      (dec_inst0),
        .dec_inst1      (dec_inst1),
        .dec_pc0        (dec_pc0),
        .dec_pc1        (dec_pc1),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [7:0] a);
        return mem[a[7:2]];
    endfunction

    // Instruction memory: one-cycle read latency.
    always @(posedge clk) begin
        inst1 <= mw(pc);
        inst2 <= mw(pc + 8'd4);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the fetch behaviour in terms of a plain queue of entries.
    task automatic model_next();
        ent_t       q[$];
        int         occ;
        int         npop;
        int         npush;
        bit         hit;
        logic [31:0] w0, w1;
        q = m_q;
        hit = 1'b0;
        if (!reset_n) begin
            q.delete();
            n_pc = 8'h00; n_pend = 1'b0; n_pend_pc = 8'h00; n_halted = 1'b0;
        end else if (redirect_valid) begin
            q.delete();
            n_pc = redirect_pc & 8'hFC; n_pend = 1'b0; n_pend_pc = m_pend_pc; n_halted = 1'b0;
        end else begin
            occ = q.size() + (m_pend ? 2 : 0);
            npop = dec_ready ? ((q.size() >= 2) ? 2 : q.size()) : 0;
            for (int i = 0; i < npop; i++) void'(q.pop_front());
            if (m_pend) begin
                w0 = mw(m_pend_pc);
                w1 = mw(m_pend_pc + 8'd4);
                npush = 2;
`ifdef FETCH_CTRL_HALT_EN
                if (w0 == 32'h0) begin npush = 0; hit = 1'b1; end
                else if (w1 == 32'h0) begin npush = 1; hit = 1'b1; end
`endif
                if (npush >= 1) q.push_back(ent_t'{inst: w0, pc: m_pend_pc});
                if (npush == 2) q.push_back(ent_t'{inst: w1, pc: m_pend_pc + 8'd4});
            end
            n_halted = m_halted || hit;
            if (!m_halted && !hit && occ <= DEPTH - 2) begin
                n_pend = 1'b1; n_pend_pc = m_pc; n_pc = m_pc + 8'd8;
            end else begin
                n_pend = 1'b0; n_pend_pc = m_pend_pc; n_pc = m_pc;
            end
        end
        n_q = q;
    endtask

    task automatic step(input bit rst, input bit rv, input logic [7:0] rpc, input bit rdy);
        reset_n        = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        model_next();
        @(posedge clk);
        m_q = n_q; m_pc = n_pc; m_pend = n_pend; m_pend_pc = n_pend_pc; m_halted = n_halted;
        @(negedge clk);
    endtask

    // Per-cycle compare against the model and the in-order acceptance check.
    always @(negedge clk) begin
        if (chk_en) begin
            #2;
            chk("pc", pc, m_pc);
            chk("halted", halted, m_halted);
            chk("valid0", dec_valid0, m_q.size() >= 1);
            chk("valid1", dec_valid1, m_q.size() >= 2);
            if (m_q.size() >= 1) begin
                chk("lane0_inst", dec_inst0, m_q[0].inst);
                chk("lane0_pc", dec_pc0, m_q[0].pc);
            end
            if (m_q.size() >= 2) begin
                chk("lane1_inst", dec_inst1, m_q[1].inst);
                chk("lane1_pc", dec_pc1, m_q[1].pc);
            end
            if (!reset_n) begin
                exp_acc = 8'h00;
            end else if (redirect_valid) begin
                exp_acc = redirect_pc & 8'hFC;
            end else if (dec_ready) begin
                if (dec_valid0) begin
                    chk("accept_seq0", dec_pc0, exp_acc);
                    exp_acc = exp_acc + 8'd4;
                end
                if (dec_valid1) begin
                    chk("accept_seq1", dec_pc1, exp_acc);
                    exp_acc = exp_acc + 8'd4;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h11 + 32'(i);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk_en = 1'b1;
        chk("rst_pc", pc, 32'h00);
        chk("rst_valid0", dec_valid0, 1'b0);
        chk("rst_valid1", dec_valid1, 1'b0);
        chk("rst_halted", halted, 1'b0);

        // Streaming from reset with decode always ready.
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("seq_pc1", pc, 32'h08);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("seq_pc2", pc, 32'h10);
        chk("c2_inst0", dec_inst0, 32'h11);
        chk("c2_pc0", dec_pc0, 32'h00);
        chk("c2_inst1", dec_inst1, 32'h12);
        chk("c2_pc1", dec_pc1, 32'h04);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("seq_pc3", pc, 32'h18);
        chk("c3_inst0", dec_inst0, 32'h13);
        chk("c3_pc0", dec_pc0, 32'h08);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Decode stall: queue fills to DEPTH and fetch freezes.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("stall_pc", pc, 32'h40);
        chk("stall_pc0", dec_pc0, 32'h20);
        chk("stall_pc1", dec_pc1, 32'h24);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Redirect with a capture and a pop in the same cycle.
        step(1'b1, 1'b1, 8'h43, 1'b1);
        chk("redir_pc", pc, 32'h40);
        chk("redir_empty1", dec_valid0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("redir_empty2", dec_valid0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("redir_first_valid", dec_valid0, 1'b1);
        chk("redir_first_pc", dec_pc0, 32'h40);
        chk("redir_first_inst", dec_inst0, 32'h21);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // PC wrap-around at the top of the address space.
        step(1'b1, 1'b1, 8'hF8, 1'b1);
        chk("wrap_pc_f8", pc, 32'hF8);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("wrap_pc_00", pc, 32'h00);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("wrap_lane_f8", dec_pc0, 32'hF8);
        chk("wrap_lane_fc", dec_pc1, 32'hFC);
        chk("wrap_inst_f8", dec_inst0, 32'h4F);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("wrap_lane_00", dec_pc0, 32'h00);
        chk("wrap_inst_00", dec_inst0, 32'h11);

        // Irregular decode readiness.
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 8'h00, (i % 3) != 0);

`ifdef FETCH_CTRL_HALT_EN
        // Halt word in lane 1 of the pair at 0x10.
        mem[5] = 32'h0000_0000;
        step(1'b1, 1'b1, 8'h10, 1'b0);
        chk("halt_pc10", pc, 32'h10);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("halt_flag", halted, 1'b1);
        chk("halt_pc_frozen", pc, 32'h18);
        chk("halt_lane0_pc", dec_pc0, 32'h10);
        chk("halt_lane0_inst", dec_inst0, 32'h15);
        chk("halt_lane1_none", dec_valid1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("halt_drained", dec_valid0, 1'b0);
        chk("halt_still_pc", pc, 32'h18);
        mem[5] = 32'h16;
        step(1'b1, 1'b1, 8'h00, 1'b1);
        chk("halt_cleared", halted, 1'b0);
        chk("halt_resume_pc", pc, 32'h00);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
`endif

        // Reset wins over a simultaneous redirect.
        step(1'b0, 1'b1, 8'h80, 1'b1);
        chk("rst_over_redir_pc", pc, 32'h00);
        chk("rst_over_redir_v0", dec_valid0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
